// File: rtl/alu_exec_pkg.sv
// Shared encodings for the ALU execution controller: opcodes, ALU S codes, FSM states and op decode.
// ALU_EXEC_FLAGS_EN (in alu_exec_ctrl) selects whether the cf/zf flag register exists.
package alu_exec_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b0101;
  localparam logic [3:0] OP_LDI = 4'b0110;

  localparam logic [3:0] S_ADD  = 4'b1001;
  localparam logic [3:0] S_SUB  = 4'b0110;
  localparam logic [3:0] S_AND  = 4'b1011;
  localparam logic [3:0] S_NOT  = 4'b0101;
  localparam logic [3:0] S_PASS = 4'b1100;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  typedef enum logic [1:0] {A_ZERO, A_RS, A_IMM} asel_t;

  typedef struct packed {
    logic       m;
    logic [3:0] s;
    asel_t      a_sel;
    logic       b_rd;
    logic       wr;
    logic       flg;
    logic       ill;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_NOP: ;
      OP_ADD: begin d.m = 1'b1; d.s = S_ADD; d.a_sel = A_RS; d.b_rd = 1'b1; d.wr = 1'b1; d.flg = 1'b1; end
      OP_SUB: begin d.m = 1'b1; d.s = S_SUB; d.a_sel = A_RS; d.b_rd = 1'b1; d.wr = 1'b1; d.flg = 1'b1; end
      OP_AND: begin d.m = 1'b1; d.s = S_AND; d.a_sel = A_RS; d.b_rd = 1'b1; d.wr = 1'b1; end
      OP_NOT: begin d.m = 1'b1; d.s = S_NOT; d.b_rd = 1'b1; d.wr = 1'b1; end
      OP_MOV: begin d.m = 1'b1; d.s = S_PASS; d.a_sel = A_RS; d.wr = 1'b1; end
      OP_LDI: begin d.s = S_PASS; d.a_sel = A_IMM; d.wr = 1'b1; end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_file4x8.sv
// Register file: two combinational read ports, a debug read port, one synchronous write port.
// Asynchronous clear on rst; a write becomes visible on the read ports the cycle after it is issued.
module reg_file4x8 #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [RADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]  rdata_a,
  input  logic [RADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]  rdata_b,
  input  logic [RADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  logic [DATA_W-1:0] mem [2**RADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**RADDR_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_sel];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Four-state (IDLE/READ/EXEC/WB) sequencer driving an external ALU; one instruction per 4 cycles.
// Macro ALU_EXEC_FLAGS_EN adds the cf/zf flag register; without it cf/zf are tied to 0.
module alu_exec_ctrl
  import alu_exec_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_instr,
  input  logic [DATA_W-1:0]  in_imm,
  output logic               alu_m,
  output logic [3:0]         alu_s,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_t,
  input  logic               alu_cf,
  input  logic               alu_zf,
  output logic               done,
  output logic               illegal,
  output logic               cf,
  output logic               zf,
  input  logic [RADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  state_t             state, nstate;
  logic [7:0]         instr_q;
  logic [DATA_W-1:0]  imm_q;
  logic [DATA_W-1:0]  res_q;
  logic [DATA_W-1:0]  rdata_a, rdata_b;
  dec_t               dec;
  logic [RADDR_W-1:0] rd, rs;
  logic               we;

  assign dec = decode(instr_q[7:4]);
  assign rd  = instr_q[3:2];
  assign rs  = instr_q[1:0];
  assign we  = (state == WB) && dec.wr;

  assign in_ready = (state == IDLE) && !rst;
  assign done     = (state == WB);
  assign illegal  = (state == WB) && dec.ill;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid && in_ready) nstate = READ;
      READ:    nstate = EXEC;
      EXEC:    nstate = WB;
      default: nstate = IDLE;
    endcase
  end

  // ALU controls are loaded from the decode leaving READ and cleared leaving EXEC,
  // so the ALU sees 0/0000 during WB and while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      instr_q <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      alu_m   <= 1'b0;
      alu_s   <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && in_valid) begin
        instr_q <= in_instr;
        imm_q   <= in_imm;
      end
      if (state == READ) begin
        alu_m <= dec.m;
        alu_s <= dec.s;
        case (dec.a_sel)
          A_RS:    alu_a <= rdata_a;
          A_IMM:   alu_a <= imm_q;
          default: alu_a <= '0;
        endcase
        alu_b <= dec.b_rd ? rdata_b : '0;
      end
      if (state == EXEC) begin
        res_q <= alu_t;
        alu_m <= 1'b0;
        alu_s <= '0;
        alu_a <= '0;
        alu_b <= '0;
      end
    end
  end

`ifdef ALU_EXEC_FLAGS_EN
  logic res_cf, res_zf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cf <= 1'b0;
      res_zf <= 1'b0;
      cf     <= 1'b0;
      zf     <= 1'b0;
    end else begin
      if (state == EXEC) begin
        res_cf <= alu_cf;
        res_zf <= alu_zf;
      end
      if (state == WB && dec.flg) begin
        cf <= res_cf;
        zf <= res_zf;
      end
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{alu_cf, alu_zf, dec.flg};
  assign cf = 1'b0;
  assign zf = 1'b0;
`endif

  reg_file4x8 #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_regs (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (rd),
    .wdata    (res_q),
    .raddr_a  (rs),
    .rdata_a  (rdata_a),
    .raddr_b  (rd),
    .rdata_b  (rdata_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural model of the external ALU.
module tb_alu_exec_ctrl;

`ifdef ALU_EXEC_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_instr = 8'h00;
  logic [7:0] in_imm = 8'h00;
  logic       alu_m;
  logic [3:0] alu_s;
  logic [7:0] alu_a, alu_b, alu_t;
  logic       alu_cf, alu_zf;
  logic       done, illegal, cf, zf;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  int tests = 0;
  int fails = 0;

  logic       ex_m, wb_m;
  logic [3:0] ex_s, wb_s;
  logic [7:0] ex_a, ex_b, wb_dbg;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(8), .RADDR_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm(in_imm), .alu_m(alu_m), .alu_s(alu_s),
    .alu_a(alu_a), .alu_b(alu_b), .alu_t(alu_t), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .done(done), .illegal(illegal), .cf(cf), .zf(zf),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // External ALU: SUB computes B-A, carry out is the borrow bit.
  always_comb begin
    alu_t  = 8'h00;
    alu_cf = 1'b0;
    case ({alu_m, alu_s})
      5'b1_1001: {alu_cf, alu_t} = {1'b0, alu_a} + {1'b0, alu_b};
      5'b1_0110: {alu_cf, alu_t} = {1'b0, alu_b} - {1'b0, alu_a};
      5'b1_1011: alu_t = alu_a & alu_b;
      5'b1_0101: alu_t = ~alu_b;
      5'b1_1100: alu_t = alu_a;
      5'b0_1100: alu_t = alu_a;
      default:   alu_t = 8'h00;
    endcase
    alu_zf = (alu_t == 8'h00);
  end

  task automatic rd_reg(input logic [1:0] idx, output logic [7:0] val);
    dbg_sel = idx;
    #1;
    val = dbg_data;
  endtask

  // Issues one instruction from a negedge and returns at the negedge after WB.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [7:0] imm, input logic exp_ill);
    int k, w;
    dbg_sel  = rd;
    in_valid = 1'b1;
    in_instr = {op, rd, rs};
    in_imm   = imm;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = 8'hFF;
    in_imm   = 8'h00;
    k = 1;
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
      if (k == 2) begin ex_m = alu_m; ex_s = alu_s; ex_a = alu_a; ex_b = alu_b; end
    end
    wb_m = alu_m; wb_s = alu_s; wb_dbg = dbg_data;
    tests++; if (k !== 3) begin fails++; $display("FAIL latency op=%b got %0d cycles exp 3", op, k); end
    tests++; if (illegal !== exp_ill) begin fails++; $display("FAIL illegal op=%b got %b exp %b", op, illegal, exp_ill); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    #3;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", in_ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", done); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rel_ready got %b exp 1", in_ready); end
    tests++; if ({cf, zf, alu_m, alu_s} !== 7'b0) begin fails++; $display("FAIL rel_ctl got %b exp 0", {cf, zf, alu_m, alu_s}); end
    for (int i = 0; i < 4; i++) begin
      rd_reg(i[1:0], v);
      tests++; if (v !== 8'h00) begin fails++; $display("FAIL rel_r%0d got %h exp 00", i, v); end
    end
    @(negedge clk);
  endtask

  task automatic test_add_flags();
    logic [7:0] v;
    issue(4'b0110, 2'd1, 2'd0, 8'hF0, 1'b0);
    issue(4'b0110, 2'd2, 2'd0, 8'h20, 1'b0);
    issue(4'b0001, 2'd1, 2'd2, 8'h00, 1'b0);
    rd_reg(2'd1, v);
    tests++; if (v !== 8'h10) begin fails++; $display("FAIL add_r1 got %h exp 10", v); end
    rd_reg(2'd2, v);
    tests++; if (v !== 8'h20) begin fails++; $display("FAIL add_r2 got %h exp 20", v); end
    tests++; if ({cf, zf} !== {FL, 1'b0}) begin fails++; $display("FAIL add_flags got %b exp %b", {cf, zf}, {FL, 1'b0}); end
  endtask

  task automatic test_sub_not();
    logic [7:0] v;
    issue(4'b0110, 2'd1, 2'd0, 8'h05, 1'b0);
    issue(4'b0110, 2'd2, 2'd0, 8'h05, 1'b0);
    issue(4'b0010, 2'd1, 2'd2, 8'h00, 1'b0);
    rd_reg(2'd1, v);
    tests++; if (v !== 8'h00) begin fails++; $display("FAIL sub_r1 got %h exp 00", v); end
    tests++; if ({cf, zf} !== {1'b0, FL}) begin fails++; $display("FAIL sub_flags got %b exp %b", {cf, zf}, {1'b0, FL}); end
    issue(4'b0100, 2'd1, 2'd0, 8'h00, 1'b0);
    rd_reg(2'd1, v);
    tests++; if (v !== 8'hFF) begin fails++; $display("FAIL not_r1 got %h exp ff", v); end
    tests++; if ({cf, zf} !== {1'b0, FL}) begin fails++; $display("FAIL not_flags got %b exp %b", {cf, zf}, {1'b0, FL}); end
  endtask

  task automatic test_alu_ctl();
    logic [7:0] v;
    issue(4'b0101, 2'd3, 2'd2, 8'h00, 1'b0);
    tests++; if ({ex_m, ex_s, ex_a, ex_b} !== {1'b1, 4'b1100, 8'h05, 8'h00}) begin
      fails++; $display("FAIL mov_exec got %b %b %h %h exp 1 1100 05 00", ex_m, ex_s, ex_a, ex_b); end
    tests++; if ({wb_m, wb_s} !== 5'b0) begin fails++; $display("FAIL wb_ctl got %b exp 00000", {wb_m, wb_s}); end
    rd_reg(2'd3, v);
    tests++; if (v !== 8'h05) begin fails++; $display("FAIL mov_r3 got %h exp 05", v); end
  endtask

  task automatic test_illegal();
    logic [7:0] v;
    issue(4'b1111, 2'd1, 2'd2, 8'h77, 1'b1);
    rd_reg(2'd1, v);
    tests++; if (v !== 8'hFF) begin fails++; $display("FAIL ill_r1 got %h exp ff", v); end
    rd_reg(2'd2, v);
    tests++; if (v !== 8'h05) begin fails++; $display("FAIL ill_r2 got %h exp 05", v); end
    tests++; if ({cf, zf} !== {1'b0, FL}) begin fails++; $display("FAIL ill_flags got %b exp %b", {cf, zf}, {1'b0, FL}); end
  endtask

  task automatic test_rd_eq_rs();
    logic [7:0] v;
    issue(4'b0110, 2'd0, 2'd0, 8'h81, 1'b0);
    issue(4'b0001, 2'd0, 2'd0, 8'h00, 1'b0);
    tests++; if ({ex_a, ex_b} !== 16'h8181) begin fails++; $display("FAIL same_ops got %h %h exp 81 81", ex_a, ex_b); end
    rd_reg(2'd0, v);
    tests++; if (v !== 8'h02) begin fails++; $display("FAIL same_r0 got %h exp 02", v); end
    tests++; if ({cf, zf} !== {FL, 1'b0}) begin fails++; $display("FAIL same_flags got %b exp %b", {cf, zf}, {FL, 1'b0}); end
  endtask

  task automatic test_dbg_wb();
    logic [7:0] v;
    issue(4'b0110, 2'd0, 2'd0, 8'h5A, 1'b0);
    tests++; if (wb_dbg !== 8'h02) begin fails++; $display("FAIL dbg_in_wb got %h exp 02", wb_dbg); end
    rd_reg(2'd0, v);
    tests++; if (v !== 8'h5A) begin fails++; $display("FAIL dbg_after got %h exp 5a", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prog [3];
    logic [7:0] imms [3];
    logic [7:0] v;
    int acc [3];
    int n, ndone;
    prog[0] = 8'b0110_01_00; imms[0] = 8'h11;
    prog[1] = 8'b0110_10_00; imms[1] = 8'h22;
    prog[2] = 8'b0110_11_00; imms[2] = 8'h33;
    n = 0; ndone = 0;
    for (int c = 0; c < 24; c++) begin
      if (n < 3) begin in_valid = 1'b1; in_instr = prog[n]; in_imm = imms[n]; end
      else in_valid = 1'b0;
      #1;
      if (done) ndone++;
      if (in_valid && in_ready) begin acc[n] = c; n++; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++; if (n !== 3) begin fails++; $display("FAIL b2b_accepts got %0d exp 3", n); end
    tests++; if (ndone !== 3) begin fails++; $display("FAIL b2b_dones got %0d exp 3", ndone); end
    if (n == 3) begin
      tests++; if (acc[1] - acc[0] !== 4) begin fails++; $display("FAIL b2b_gap01 got %0d exp 4", acc[1] - acc[0]); end
      tests++; if (acc[2] - acc[1] !== 4) begin fails++; $display("FAIL b2b_gap12 got %0d exp 4", acc[2] - acc[1]); end
    end
    rd_reg(2'd2, v);
    tests++; if (v !== 8'h22) begin fails++; $display("FAIL b2b_r2 got %h exp 22", v); end
    rd_reg(2'd3, v);
    tests++; if (v !== 8'h33) begin fails++; $display("FAIL b2b_r3 got %h exp 33", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int ndone;
    in_valid = 1'b1; in_instr = 8'b0110_11_00; in_imm = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if ({done, in_ready, alu_m} !== 3'b000) begin fails++; $display("FAIL mid_rst got %b exp 000", {done, in_ready, alu_m}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b exp 1", in_ready); end
    ndone = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (done) ndone++; end
    tests++; if (ndone !== 0) begin fails++; $display("FAIL mid_done got %0d exp 0", ndone); end
    rd_reg(2'd3, v);
    tests++; if (v !== 8'h00) begin fails++; $display("FAIL mid_r3 got %h exp 00", v); end
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_sub_not();
    test_alu_ctl();
    test_illegal();
    test_rd_eq_rs();
    test_dbg_wb();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
